// File: rtl/nishit_mult_pkg.sv
// nishit_mult_pkg: shared widths and types for the pipelined 4x4 multiplier.
package nishit_mult_pkg;
    localparam int WIDTH  = 4;
    localparam int PROD_W = 2 * WIDTH;
    typedef logic [WIDTH-1:0]  operand_t;
    typedef logic [PROD_W-1:0] product_t;
    typedef operand_t [WIDTH-1:0] pp_array_t;
endpackage

// File: rtl/mult_pp_adder.sv
// mult_pp_adder: sums the registered partial-product rows, row i weighted by 2^i.
module mult_pp_adder
    import nishit_mult_pkg::*;
(
    input  pp_array_t pp,
    output product_t  sum
);
    always_comb begin
        sum = '0;
        for (int i = 0; i < WIDTH; i++) sum = sum + (product_t'(pp[i]) << i);
    end
endmodule

// File: rtl/nishit0072e_multiplier.sv
// nishit0072e_multiplier: two-stage pipelined 4x4 unsigned multiplier on the Tiny Tapeout pin set.
// Define MULT_VALID_EN to drive a product-valid flag on uio_out[0].
module nishit0072e_multiplier
    import nishit_mult_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    operand_t  a, b;
    pp_array_t pp_d, pp_q;
    product_t  sum, prod_q;
    logic      unused_uio;
    assign a = ui_in[WIDTH-1:0];
    assign b = ui_in[PROD_W-1:WIDTH];
    assign unused_uio = &{1'b0, uio_in};
    always_comb begin
        pp_d = '0;
        for (int i = 0; i < WIDTH; i++) pp_d[i] = {WIDTH{b[i]}} & a;
    end
    mult_pp_adder u_adder (.pp(pp_q), .sum(sum));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pp_q   <= '0;
            prod_q <= '0;
        end else if (ena) begin
            pp_q   <= pp_d;
            prod_q <= sum;
        end
    end
    assign uo_out = prod_q;
`ifdef MULT_VALID_EN
    logic v1_q, v2_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else if (ena) begin
            v1_q <= 1'b1;
            v2_q <= v1_q;
        end
    end
    assign uio_out = {7'b0, v2_q};
    assign uio_oe  = 8'h01;
`else
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;
`endif
endmodule

// File: tb/tb_nishit0072e_multiplier.sv
// tb_nishit0072e_multiplier: directed table, corner sequences and random stimulus against a delay-queue model.
module tb_nishit0072e_multiplier;
    logic clk = 1'b0, rst = 1'b1, ena = 1'b0;
    logic [7:0] ui_in = 8'h00, uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;
    int vectors = 0, miscompares = 0;
    logic [7:0] exp_q[$];
    logic       val_q[$];
    typedef struct {logic [7:0] ui; logic [7:0] exp;} vec_t;
    vec_t dir[5];

    nishit0072e_multiplier dut (
        .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] prod(logic [7:0] u);
        return 8'(u[3:0]) * 8'(u[7:4]);
    endfunction

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q = '{8'h00, 8'h00};
        val_q = '{1'b0, 1'b0};
    endtask

    // Each enabled edge shifts one product in and the oldest out to uo_out.
    task automatic tick();
        @(posedge clk);
        if (!rst && ena) begin
            exp_q.push_back(prod(ui_in));
            void'(exp_q.pop_front());
            val_q.push_back(1'b1);
            void'(val_q.pop_front());
        end
        #1;
    endtask

    task automatic check_all(string name);
        check(name, uo_out, exp_q[0]);
`ifdef MULT_VALID_EN
        check({name, "_vld"}, uio_out, {7'b0, val_q[0]});
        check({name, "_oe"}, uio_oe, 8'h01);
`else
        check({name, "_uio"}, uio_out, 8'h00);
        check({name, "_oe"}, uio_oe, 8'h00);
`endif
    endtask

    initial begin
        dir = '{'{8'h23, 8'd6}, '{8'h57, 8'd35}, '{8'hFF, 8'd225}, '{8'h0A, 8'd0}, '{8'h1F, 8'd15}};
        model_reset();
        ui_in = 8'hFF;
        ena = 1'b1;
        #2;
        check_all("reset");
        check("reset_out", uo_out, 8'h00);
        tick();
        check_all("reset_edge");
        rst = 1'b0;
        tick();
        check_all("release1");
        check("release1_out", uo_out, 8'h00);
        tick();
        check_all("release2");
        check("release2_out", uo_out, 8'd225);

        for (int i = 0; i < 5; i++) begin
            ui_in = dir[i].ui;
            tick();
            tick();
            check("directed", uo_out, dir[i].exp);
            check_all("directed_model");
        end

        ui_in = 8'h23; tick();
        ui_in = 8'h57; tick();
        check("b2b_6", uo_out, 8'd6);
        ui_in = 8'hFF; tick();
        check("b2b_35", uo_out, 8'd35);
        ui_in = 8'h00; tick();
        check("b2b_225", uo_out, 8'd225);
        tick();
        check_all("b2b_tail");

        ui_in = 8'h57;
        ena = 1'b0;
        repeat (3) begin
            tick();
            check("hold_frozen", uo_out, 8'd0);
            check_all("hold");
        end
        ena = 1'b1;
        tick();
        check_all("resume1");
        tick();
        check("resume_35", uo_out, 8'd35);
        check_all("resume2");

        ui_in = 8'hFF;
        tick();
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("rst_mid_out", uo_out, 8'h00);
        check_all("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        ui_in = 8'h00;
        repeat (3) begin
            tick();
            check("no_stale", uo_out, 8'h00);
            check_all("after_rst");
        end

        repeat (400) begin
            ui_in = 8'($urandom);
            ena = ($urandom_range(3) != 0);
            if ($urandom_range(40) == 0) begin
                #2 rst = 1'b1;
                model_reset();
                #1 check_all("rand_rst");
                #1 rst = 1'b0;
            end
            tick();
            check_all("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
